// File: rtl/pulse_burst_sequencer.sv
// Burst sequencer: turns one arm request into N start strobes spaced by a programmable gap.
// Optional PULSE_SEQ_CONTINUOUS_EN: burst_count==0 repeats forever until abort or reset.
module pulse_burst_sequencer #(
    parameter int unsigned CNT_W   = 8,
    parameter int unsigned INT_W   = 16,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             gen_ready,
    input  logic             pulse_in,
    input  logic             arm,
    input  logic             abort,
    input  logic [CNT_W-1:0] burst_count,
    input  logic [INT_W-1:0] interval,
    output logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_issued,
    output logic             timeout_err
);

`ifdef PULSE_SEQ_CONTINUOUS_EN
    localparam bit Continuous = 1'b1;
`else
    localparam bit Continuous = 1'b0;
`endif

    localparam int unsigned TMO_W = $clog2(TIMEOUT);
    localparam logic [TMO_W-1:0] TmoLoad = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle,
        StWaitReady,
        StFire,
        StWaitPulse,
        StGap,
        StDone
    } state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [INT_W-1:0] interval_q;
    logic [INT_W-1:0] gap_q;
    logic [TMO_W-1:0] tmo_q;
    logic             pulse_q;
    logic             gen_ready_q;
    logic             seen_rise_q;

    logic             pulse_rise;
    logic             pulse_fall;
    logic [CNT_W-1:0] pulses_next;

    assign pulse_rise  = pulse_in & ~pulse_q;
    assign pulse_fall  = ~pulse_in & pulse_q & seen_rise_q;
    assign pulses_next = pulses_issued + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            count_q       <= '0;
            interval_q    <= '0;
            gap_q         <= '0;
            tmo_q         <= '0;
            pulse_q       <= 1'b0;
            gen_ready_q   <= 1'b0;
            seen_rise_q   <= 1'b0;
            start         <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pulses_issued <= '0;
            timeout_err   <= 1'b0;
        end else begin
            pulse_q     <= pulse_in;
            gen_ready_q <= gen_ready;
            start       <= 1'b0;
            done        <= 1'b0;
            if (abort) begin
                state_q <= StIdle;
                busy    <= 1'b0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (arm) begin
                            count_q       <= burst_count;
                            interval_q    <= interval;
                            pulses_issued <= '0;
                            timeout_err   <= 1'b0;
                            busy          <= 1'b1;
                            if (burst_count == '0 && !Continuous) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                            end else if (gen_ready_q) begin
                                state_q <= StFire;
                                start   <= 1'b1;
                            end else begin
                                state_q <= StWaitReady;
                            end
                        end
                    end
                    StWaitReady: begin
                        if (gen_ready_q) begin
                            state_q <= StFire;
                            start   <= 1'b1;
                        end
                    end
                    StFire: begin
                        if (!gen_ready_q) begin
                            state_q <= StWaitReady;
                        end else begin
                            state_q     <= StWaitPulse;
                            tmo_q       <= TmoLoad;
                            seen_rise_q <= 1'b0;
                        end
                    end
                    StWaitPulse: begin
                        // Generator reset discards the pulse in flight; it is re-fired later.
                        if (!gen_ready_q) begin
                            state_q <= StWaitReady;
                        end else if (pulse_fall) begin
                            pulses_issued <= pulses_next;
                            if (count_q != '0 && pulses_next == count_q) begin
                                state_q <= StDone;
                                done    <= 1'b1;
                            end else if (interval_q == '0) begin
                                state_q <= StFire;
                                start   <= 1'b1;
                            end else begin
                                state_q <= StGap;
                                gap_q   <= interval_q - INT_W'(1);
                            end
                        end else if (tmo_q == TMO_W'(1)) begin
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                            state_q     <= StIdle;
                        end else begin
                            tmo_q <= tmo_q - TMO_W'(1);
                            if (pulse_rise) seen_rise_q <= 1'b1;
                        end
                    end
                    StGap: begin
                        if (!gen_ready_q) begin
                            state_q <= StWaitReady;
                        end else if (gap_q == '0) begin
                            state_q <= StFire;
                            start   <= 1'b1;
                        end else begin
                            gap_q <= gap_q - INT_W'(1);
                        end
                    end
                    StDone: begin
                        busy    <= 1'b0;
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulse_burst_sequencer.sv
// Self-checking bench for pulse_burst_sequencer: vector table, directed corner cases and
// randomized bursts checked against start/done timing derived from the burst rules.
module tb_pulse_burst_sequencer;
    localparam int CNT_W   = 8;
    localparam int INT_W   = 16;
    localparam int TIMEOUT = 16;
`ifdef PULSE_SEQ_CONTINUOUS_EN
    localparam bit CONT = 1'b1;
`else
    localparam bit CONT = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             gen_ready = 1'b1;
    logic             pulse_in = 1'b0;
    logic             arm = 1'b0;
    logic             abort = 1'b0;
    logic [CNT_W-1:0] burst_count = '0;
    logic [INT_W-1:0] interval = '0;
    logic             start, busy, done, timeout_err;
    logic [CNT_W-1:0] pulses_issued;

    pulse_burst_sequencer #(.CNT_W(CNT_W), .INT_W(INT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .gen_ready(gen_ready), .pulse_in(pulse_in), .arm(arm),
        .abort(abort), .burst_count(burst_count), .interval(interval), .start(start),
        .busy(busy), .done(done), .pulses_issued(pulses_issued), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Generator model: registered response, pulse_in high for plen cycles after start is seen.
    int   plen = 2;
    bit   gen_stuck = 1'b0;
    int   left = 0;
    logic gen_s;
    always @(posedge clk) begin
        gen_s = start;
        #1;
        if (reset || !gen_ready || gen_stuck) left = 0;
        else if (gen_s) left = plen;
        else if (left > 0) left--;
        pulse_in = (left > 0);
    end

    int               start_q[$];
    int               done_q[$];
    int               pi_q[$];
    logic [CNT_W-1:0] pi_prev = '0;
    always @(negedge clk) begin
        if (start) start_q.push_back(cyc);
        if (done) done_q.push_back(cyc);
        if (pulses_issued != pi_prev && pulses_issued != '0) pi_q.push_back(int'(pulses_issued));
        pi_prev = pulses_issued;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic launch(input int cnt, input int ivl, input int pl, output int a);
        start_q.delete();
        done_q.delete();
        pi_q.delete();
        plen        = pl;
        burst_count = CNT_W'(cnt);
        interval    = INT_W'(ivl);
        arm         = 1'b1;
        a           = cyc + 1;
        tick();
        arm = 1'b0;
    endtask

    // Waits for busy to drop; noisy mode pokes arm/config mid-burst, which must be ignored.
    task automatic wait_idle(input bit noisy, output int fall_cyc);
        int n = 0;
        while (busy && n < 3000) begin
            if (noisy) begin
                arm         = ($urandom_range(0, 3) == 0);
                burst_count = CNT_W'($urandom);
                interval    = INT_W'($urandom_range(0, 50));
            end
            tick();
            n++;
        end
        arm      = 1'b0;
        fall_cyc = cyc;
        check("burst_terminates", int'(n < 3000), 1);
    endtask

    task automatic compare_burst(input string tag, input int a, input int cnt, input int ivl,
                                 input int pl, input int fall_cyc);
        int sp       = pl + ivl + 2;
        int exp_done = (cnt == 0) ? a : a + (cnt - 1) * sp + pl + 2;
        check({tag, " start_count"}, start_q.size(), cnt);
        for (int k = 0; k < cnt && k < start_q.size(); k++)
            check($sformatf("%s start%0d_cycle", tag, k), start_q[k], a + k * sp);
        check({tag, " done_count"}, done_q.size(), 1);
        if (done_q.size() > 0) check({tag, " done_cycle"}, done_q[0], exp_done);
        check({tag, " busy_fall_cycle"}, fall_cyc, exp_done + 1);
        check({tag, " pulses_issued"}, int'(pulses_issued), cnt);
        check({tag, " pulses_seq_len"}, pi_q.size(), cnt);
        for (int k = 0; k < cnt && k < pi_q.size(); k++)
            check($sformatf("%s pulses_seq%0d", tag, k), pi_q[k], k + 1);
        check({tag, " timeout_err"}, int'(timeout_err), 0);
    endtask

    typedef struct {
        int cnt;
        int ivl;
        int pl;
        int exp_starts;
        int exp_done_off;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   a, f, g, ab, completed;
        vecs[0] = '{cnt: 3, ivl: 4, pl: 2, exp_starts: 3, exp_done_off: 20};
        vecs[1] = '{cnt: 1, ivl: 0, pl: 1, exp_starts: 1, exp_done_off: 3};
        vecs[2] = '{cnt: 2, ivl: 0, pl: 3, exp_starts: 2, exp_done_off: 10};
        vecs[3] = '{cnt: 4, ivl: 1, pl: 1, exp_starts: 4, exp_done_off: 15};
        vecs[4] = '{cnt: 0, ivl: 3, pl: 2, exp_starts: 0, exp_done_off: 0};
        vecs[5] = '{cnt: 5, ivl: 0, pl: 4, exp_starts: 5, exp_done_off: 30};

        repeat (3) tick();
        check("reset start", int'(start), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);
        check("reset pulses_issued", int'(pulses_issued), 0);
        check("reset timeout_err", int'(timeout_err), 0);
        reset = 1'b0;
        repeat (3) tick();

        foreach (vecs[i]) begin
            if (!(CONT && vecs[i].cnt == 0)) begin
                launch(vecs[i].cnt, vecs[i].ivl, vecs[i].pl, a);
                wait_idle(1'b0, f);
                check($sformatf("vec%0d starts", i), start_q.size(), vecs[i].exp_starts);
                if (done_q.size() > 0)
                    check($sformatf("vec%0d done_off", i), done_q[0] - a, vecs[i].exp_done_off);
                compare_burst($sformatf("vec%0d", i), a, vecs[i].cnt, vecs[i].ivl, vecs[i].pl, f);
                repeat (2) tick();
            end
        end

        // Reset in the middle of WAIT_PULSE.
        launch(3, 4, 5, a);
        while (cyc < a + 2) tick();
        reset = 1'b1;
        tick();
        check("midreset start", int'(start), 0);
        check("midreset busy", int'(busy), 0);
        check("midreset done", int'(done), 0);
        check("midreset pulses_issued", int'(pulses_issued), 0);
        check("midreset timeout_err", int'(timeout_err), 0);
        reset = 1'b0;
        start_q.delete();
        repeat (40) tick();
        check("midreset no_more_starts", start_q.size(), 0);
        check("midreset stays_idle", int'(busy), 0);

        // Generator not ready at arm time.
        gen_ready = 1'b0;
        repeat (3) tick();
        launch(1, 0, 2, a);
        check("notready busy", int'(busy), 1);
        repeat (10) tick();
        check("notready no_start_yet", start_q.size(), 0);
        gen_ready = 1'b1;
        g = cyc;
        wait_idle(1'b0, f);
        check("notready start_count", start_q.size(), 1);
        if (start_q.size() > 0) check("notready start_cycle", start_q[0], g + 2);
        check("notready done_count", done_q.size(), 1);
        if (done_q.size() > 0) check("notready done_cycle", done_q[0], g + 6);
        repeat (2) tick();

        // Generator never completes the pulse.
        gen_stuck = 1'b1;
        launch(2, 0, 2, a);
        while (cyc < a + 15) tick();
        check("timeout err_early", int'(timeout_err), 0);
        tick();
        check("timeout err_set", int'(timeout_err), 1);
        check("timeout busy", int'(busy), 0);
        repeat (10) tick();
        check("timeout start_count", start_q.size(), 1);
        check("timeout done_count", done_q.size(), 0);
        check("timeout err_sticky", int'(timeout_err), 1);
        gen_stuck = 1'b0;
        launch(1, 0, 2, a);
        check("timeout err_cleared_by_arm", int'(timeout_err), 0);
        wait_idle(1'b0, f);
        compare_burst("after_timeout", a, 1, 0, 2, f);
        repeat (2) tick();

        // Abort during the gap after two pulses.
        launch(5, 6, 2, a);
        while (cyc < a + 15) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort busy", int'(busy), 0);
        check("abort pulses_issued", int'(pulses_issued), 2);
        repeat (20) tick();
        check("abort start_count", start_q.size(), 2);
        check("abort done_count", done_q.size(), 0);
        check("abort pulses_hold", int'(pulses_issued), 2);

        // Abort and arm together in IDLE: arm loses.
        start_q.delete();
        abort       = 1'b1;
        arm         = 1'b1;
        burst_count = CNT_W'(2);
        tick();
        abort = 1'b0;
        arm   = 1'b0;
        repeat (5) tick();
        check("abort_arm busy", int'(busy), 0);
        check("abort_arm start_count", start_q.size(), 0);

        // Generator reset mid-pulse: pulse not counted, re-fired after ready returns.
        launch(1, 0, 3, a);
        while (cyc < a + 1) tick();
        gen_ready = 1'b0;
        repeat (3) tick();
        gen_ready = 1'b1;
        wait_idle(1'b0, f);
        check("genreset start_count", start_q.size(), 2);
        check("genreset done_count", done_q.size(), 1);
        check("genreset pulses_issued", int'(pulses_issued), 1);
        repeat (2) tick();

        // Randomized bursts with arm/config noise while busy.
        for (int r = 0; r < 10; r++) begin
            int cnt = $urandom_range(1, 5);
            int ivl = $urandom_range(0, 6);
            int pl  = $urandom_range(1, 4);
            launch(cnt, ivl, pl, a);
            wait_idle(1'b1, f);
            compare_burst($sformatf("rand%0d", r), a, cnt, ivl, pl, f);
            repeat ($urandom_range(1, 4)) tick();
        end

        if (CONT) begin
            launch(0, 0, 1, a);
            repeat (960) tick();
            abort = 1'b1;
            ab    = cyc + 1;
            tick();
            abort = 1'b0;
            repeat (5) tick();
            completed = 0;
            foreach (start_q[i]) if (start_q[i] + 3 < ab) completed++;
            check("cont over_300_starts", int'(start_q.size() > 300), 1);
            check("cont pulses_wrap", int'(pulses_issued), completed % 256);
            check("cont no_done", done_q.size(), 0);
            check("cont busy_after_abort", int'(busy), 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule
